// File: rtl/packed_ascii_seg_driver.sv
// Packed-ASCII 4-digit common-anode 7-segment driver: snapshots four characters
// on LOAD, scans them continuously and pulses done once per hold interval.
module packed_ascii_seg_driver #(
    parameter int REFRESH_CYCLES = 50_000,
    parameter int HOLD_CYCLES    = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] asciiIn,
    output logic [0:6]  seg,
    output logic [3:0]  an,
    output logic        done
);
    localparam int REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [REF_W-1:0]  REF_TOP  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {LOAD, RUN} stateT;

    stateT              state, stateNext;
    logic [HOLD_W-1:0]  holdCnt;
    logic [REF_W-1:0]   refCnt;
    logic [1:0]         digitIdx;
    logic [31:0]        snapshot;
    logic [31:0]        activeChars;

    function automatic logic [0:6] decodeChar(input logic [7:0] c);
        case (c)
            8'h30:        decodeChar = 7'b0000001;
            8'h31:        decodeChar = 7'b1001111;
            8'h32:        decodeChar = 7'b0010010;
            8'h33:        decodeChar = 7'b0000110;
            8'h34:        decodeChar = 7'b1001100;
            8'h35:        decodeChar = 7'b0100100;
            8'h36:        decodeChar = 7'b0100000;
            8'h37:        decodeChar = 7'b0001111;
            8'h38:        decodeChar = 7'b0000000;
            8'h39:        decodeChar = 7'b0000100;
            8'h41, 8'h61: decodeChar = 7'b0001000;
            8'h42, 8'h62: decodeChar = 7'b1100000;
            8'h43, 8'h63: decodeChar = 7'b0110001;
            8'h44, 8'h64: decodeChar = 7'b1000010;
            8'h45, 8'h65: decodeChar = 7'b0110000;
            8'h46, 8'h66: decodeChar = 7'b0111000;
            8'h00, 8'h20: decodeChar = 7'b1111111;
            8'h2D:        decodeChar = 7'b1111110;
            default:      decodeChar = 7'b0110110;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= stateNext;
    end

    // NOTE: default assignment first, so no path through the case leaves
    // stateNext unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        case (state)
            LOAD:    stateNext = RUN;
            RUN:     if (holdCnt == HOLD_TOP) stateNext = LOAD;
            default: stateNext = LOAD;
        endcase
    end

    always_comb begin
        done = (state == RUN) && (holdCnt == HOLD_TOP);
    end

    // The counter is 0 during LOAD and counts that cycle, so done lands
    // HOLD_CYCLES-1 cycles after each LOAD and the period is HOLD_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    holdCnt <= '0;
        else if (done) holdCnt <= '0;
        else           holdCnt <= holdCnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refCnt   <= '0;
            digitIdx <= 2'd3;
        end else if (refCnt == REF_TOP) begin
            refCnt   <= '0;
            digitIdx <= digitIdx - 1'b1;
        end else begin
            refCnt   <= refCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              snapshot <= '0;
        else if (state == LOAD)  snapshot <= asciiIn;
    end

    // Bypass the snapshot during LOAD so new content reaches seg one cycle later.
    assign activeChars = (state == LOAD) ? asciiIn : snapshot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << digitIdx);
            seg <= decodeChar(activeChars[{digitIdx, 3'b000} +: 8]);
        end
    end

endmodule

// File: tb/tb_packed_ascii_seg_driver.sv
// Self-checking bench for packed_ascii_seg_driver: directed and random character
// streams compared cycle by cycle against a cycle-number based reference model.
module tb_packed_ascii_seg_driver;
    localparam int REF  = 4;
    localparam int HOLD = 40;

    localparam logic [6:0] DIGIT_GLYPH [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] HEX_GLYPH [6] = '{
        7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] asciiIn;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        done;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] snapModel = '0;

    packed_ascii_seg_driver #(
        .REFRESH_CYCLES(REF),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .asciiIn(asciiIn),
        .seg    (seg),
        .an     (an),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] refGlyph(input logic [7:0] c);
        logic [7:0] lc;
        if (c >= "0" && c <= "9") return DIGIT_GLYPH[int'(c) - 48];
        lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
        if (lc >= "a" && lc <= "f") return HEX_GLYPH[int'(lc) - 97];
        if (c == 8'h00 || c == " ") return 7'b1111111;
        if (c == "-") return 7'b1111110;
        return 7'b0110110;
    endfunction

    function automatic logic [7:0] randChar();
        case ($urandom_range(0, 5))
            0:       return 8'h30 + 8'($urandom_range(0, 9));
            1:       return 8'h41 + 8'($urandom_range(0, 5));
            2:       return 8'h61 + 8'($urandom_range(0, 5));
            3:       return ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h2D;
            4:       return 8'h00;
            default: return 8'($urandom());
        endcase
    endfunction

    task automatic checkResetValues(input string tag);
        check({tag, "_an"},   an,   4'b1111);
        check({tag, "_seg"},  seg,  7'b1111111);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // Expected outputs for cycle cyc, counted from the first edge after release.
    task automatic checkCycle();
        logic [3:0] expAn;
        logic [6:0] expSeg;
        int         idx;
        if (cyc == 0) begin
            expAn  = 4'b1111;
            expSeg = 7'b1111111;
        end else begin
            idx        = 3 - ((cyc - 1) / REF) % 4;
            expAn      = 4'b1111;
            expAn[idx] = 1'b0;
            expSeg     = refGlyph(8'(snapModel >> (8 * idx)));
        end
        check("an",   an,   expAn);
        check("seg",  seg,  expSeg);
        check("done", done, (cyc % HOLD) == HOLD - 1);
    endtask

    task automatic step();
        logic [31:0] nextSnap;
        nextSnap = (cyc % HOLD == 0) ? asciiIn : snapModel;
        @(posedge clk);
        cyc++;
        snapModel = nextSnap;
        #1;
        checkCycle();
    endtask

    // Called just after a sample point; asserts reset between edges.
    task automatic applyReset();
        #2 reset = 1'b0;
        #1 checkResetValues("rst_async");
        repeat (2) @(posedge clk);
        #1 checkResetValues("rst_held");
        @(negedge clk);
        reset     = 1'b1;
        cyc       = 0;
        snapModel = '0;
        #1 checkCycle();
    endtask

    initial begin
        reset   = 1'b1;
        asciiIn = 32'h30313233;
        #2 reset = 1'b0;
        #1 checkResetValues("init");
        repeat (3) @(posedge clk);
        #1 checkResetValues("init_held");
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        #1 checkCycle();

        // Scan order, done cadence, snapshot isolation and decode corners.
        for (int i = 0; i < 130; i++) begin
            if (cyc == 10) asciiIn = 32'h41624364;
            if (cyc == 50) asciiIn = 32'h00202D3F;
            if (cyc == 90) asciiIn = 32'h61416146;
            step();
        end

        // Random character streams changing at arbitrary cycles.
        for (int i = 0; i < 320; i++) begin
            if ($urandom_range(0, 2) == 0)
                asciiIn = {randChar(), randChar(), randChar(), randChar()};
            step();
        end

        // Reset mid-run, then again at hold count 25 with an=1101.
        applyReset();
        for (int i = 0; i < 25; i++) begin
            if (i == 3) asciiIn = {randChar(), randChar(), randChar(), randChar()};
            step();
        end
        check("pre_rst_an", an, 4'b1101);
        applyReset();
        for (int i = 0; i < 130; i++) begin
            if ($urandom_range(0, 3) == 0)
                asciiIn = {randChar(), randChar(), randChar(), randChar()};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
